// File: rtl/dcmi_dma.sv
// DMA write engine: pops captured words from the DCMI ping-pong buffer and
// writes them to a word-addressed SRAM port, circularly over a programmed block.
module dcmi_dma #(
  parameter int unsigned AW = 18
) (
  input  logic          hclk,
  input  logic          rst,
  input  logic          capture_start,
  input  logic          capture_en,
  input  logic [AW-1:0] dma_saddr,
  input  logic [AW-1:0] dma_len,
  input  logic          ppbuf_valid,
  input  logic [31:0]   ppbuf_rdata,
  output logic          ppbuf_rd,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  output logic          dma_busy,
  output logic          dma_done,
  output logic [AW-1:0] dma_wcnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ} state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_base, r_len, r_addr, r_cnt;
  logic [31:0]   r_wdata;
  logic          r_done;
  logic          w_last;

  assign w_last = (r_cnt + AW'(1)) == r_len;

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ppbuf_rd = 1'b0;
    case (r_state)
      S_IDLE: if (capture_start && (dma_len != '0)) w_next = S_WAIT;
      // Buffered data wins over capture_en so a snapshot drains before stopping.
      S_WAIT: begin
        if (ppbuf_valid) begin
          ppbuf_rd = 1'b1;
          w_next   = S_REQ;
        end else if (!capture_en) begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          if (w_last && !capture_en) w_next = S_IDLE;
          else                       w_next = S_WAIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      r_base  <= '0;
      r_len   <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (capture_start) begin
            if (dma_len != '0) begin
              r_base <= dma_saddr;
              r_addr <= dma_saddr;
              r_len  <= dma_len;
              r_cnt  <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_WAIT: if (ppbuf_valid) r_wdata <= ppbuf_rdata;
        S_REQ: begin
          if (mem_ready) begin
            if (w_last) begin
              r_done <= 1'b1;
              r_addr <= r_base;
              r_cnt  <= '0;
            end else begin
              r_addr <= r_addr + AW'(1);
              r_cnt  <= r_cnt + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = (r_state == S_REQ);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign dma_busy  = (r_state != S_IDLE);
  assign dma_done  = r_done;
  assign dma_wcnt  = r_cnt;

endmodule

// File: tb/tb_dcmi_dma.sv
// Bench for dcmi_dma: queue-based buffer/write model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_dcmi_dma;
  localparam int unsigned AW = 18;

  logic          hclk = 1'b0;
  logic          rst = 1'b1;
  logic          capture_start = 1'b0;
  logic          capture_en = 1'b0;
  logic [AW-1:0] dma_saddr = '0;
  logic [AW-1:0] dma_len = '0;
  logic          ppbuf_valid = 1'b0;
  logic [31:0]   ppbuf_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          ppbuf_rd, mem_req, dma_busy, dma_done;
  logic [AW-1:0] mem_addr, dma_wcnt;
  logic [31:0]   mem_wdata;

  dcmi_dma #(.AW(AW)) dut (
    .hclk(hclk), .rst(rst), .capture_start(capture_start), .capture_en(capture_en),
    .dma_saddr(dma_saddr), .dma_len(dma_len), .ppbuf_valid(ppbuf_valid),
    .ppbuf_rdata(ppbuf_rdata), .ppbuf_rd(ppbuf_rd), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_wcnt(dma_wcnt)
  );

  always #5 hclk = ~hclk;

  int            n_cmp = 0, n_bad = 0, cyc = 0;
  int            pop_cnt = 0, req_cnt = 0, start_cyc = 0;
  logic [31:0]   buf_q[$];
  logic [31:0]   exp_q[$];
  logic [AW-1:0] hs_addr[$];
  int            hs_cyc[$];
  int            done_cyc[$];
  bit            pop_seen = 0, stall_prev = 0, done_sched = 0, start_zero = 0, m_active = 0;
  logic [AW-1:0] m_base = '0, m_len = '0, m_k = '0, hold_addr = '0;
  logic [31:0]   hold_data = '0;
  logic [31:0]   wseed = 32'hC0DE_0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    ppbuf_valid = (buf_q.size() > 0);
    ppbuf_rdata = (buf_q.size() > 0) ? buf_q[0] : 32'h0;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      buf_q.push_back(wseed);
      wseed = wseed + 32'h0000_0101;
    end
    refresh();
  endtask

  task automatic clear_logs();
    hs_addr.delete();
    hs_cyc.delete();
    done_cyc.delete();
    req_cnt = 0;
  endtask

  // Model: each accepted block writes popped words in order to base+k (mod 2^AW),
  // k cycling 0..len-1, with a done pulse the cycle after the k=len-1 write.
  task automatic check();
    bit exp_done;
    if (rst) return;
    exp_done   = done_sched;
    done_sched = start_zero;
    start_zero = 1'b0;
    chk("done", 32'(dma_done), 32'(exp_done));
    if (dma_done) done_cyc.push_back(cyc);
    if (dma_busy && m_active) chk("wcnt", 32'(dma_wcnt), 32'(m_k));
    if (stall_prev) begin
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr", 32'(mem_addr), 32'(hold_addr));
      chk("hold_data", mem_wdata, hold_data);
    end
    if (ppbuf_rd) begin
      chk("rd_valid", 32'(ppbuf_valid), 32'd1);
      chk("rd_excl", 32'(mem_req), 32'd0);
      exp_q.push_back(ppbuf_rdata);
      pop_cnt++;
      pop_seen = 1'b1;
    end
    if (mem_req) req_cnt++;
    if (mem_req && mem_ready) begin
      chk("wr_addr", 32'(mem_addr), 32'(AW'(m_base + m_k)));
      chk("wr_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) chk("wr_data", mem_wdata, exp_q.pop_front());
      hs_addr.push_back(mem_addr);
      hs_cyc.push_back(cyc);
      m_k = m_k + AW'(1);
      if (m_k == m_len) begin
        m_k = '0;
        done_sched = 1'b1;
      end
    end
    stall_prev = mem_req && !mem_ready;
    hold_addr  = mem_addr;
    hold_data  = mem_wdata;
  endtask

  task automatic step();
    @(negedge hclk);
    check();
    @(posedge hclk);
    #1;
    cyc++;
    if (pop_seen) begin
      if (buf_q.size() > 0) void'(buf_q.pop_front());
      pop_seen = 1'b0;
      refresh();
    end
  endtask

  task automatic start(input logic [AW-1:0] sa, input logic [AW-1:0] ln, input bit accepted);
    capture_start = 1'b1;
    dma_saddr     = sa;
    dma_len       = ln;
    start_cyc     = cyc;
    if (accepted) begin
      if (ln != '0) begin
        m_base = sa; m_len = ln; m_k = '0; m_active = 1'b1;
      end else begin
        start_zero = 1'b1;
      end
    end
    step();
    capture_start = 1'b0;
  endtask

  task automatic wait_hs(input int n, input string nm);
    int t = 0;
    while (hs_addr.size() < n && t < 40) begin
      step();
      t++;
    end
    chk(nm, 32'(hs_addr.size() >= n), 32'd1);
  endtask

  task automatic wait_req();
    int t = 0;
    while (!mem_req && t < 20) begin
      step();
      t++;
    end
    chk("req_seen", 32'(mem_req), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},   32'(mem_req), 32'd0);
    chk({tag, "_rd"},    32'(ppbuf_rd), 32'd0);
    chk({tag, "_busy"},  32'(dma_busy), 32'd0);
    chk({tag, "_done"},  32'(dma_done), 32'd0);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wcnt"},  32'(dma_wcnt), 32'd0);
  endtask

  task automatic chk_basic(input string tag);
    chk({tag, "_nwr"}, hs_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_addr"}, 32'(hs_addr[i]), 32'h100 + 32'(i));
      chk({tag, "_lat"}, hs_cyc[i] - start_cyc, 2 * (i + 1));
    end
    chk({tag, "_ndone"}, done_cyc.size(), 1);
    chk({tag, "_done_at"}, done_cyc[0], hs_cyc[3] + 1);
    chk({tag, "_busy"}, 32'(dma_busy), 32'd1);
    chk({tag, "_rewind"}, 32'(mem_addr), 32'h100);
  endtask

  initial begin
    int p0;
    repeat (3) step();
    chk_reset_outs("rst0");
    rst = 1'b0;
    capture_en = 1'b1;
    mem_ready = 1'b1;
    step();

    // Basic block at 0x100, len 4
    clear_logs();
    push(4);
    start(18'h00100, 18'd4, 1'b1);
    repeat (12) step();
    chk_basic("basic");
    chk("basic_wcnt", 32'(dma_wcnt), 32'd0);

    // Backpressure on the second write of the next circular pass
    clear_logs();
    push(4);
    wait_hs(1, "bp_first");
    mem_ready = 1'b0;
    step();
    p0 = pop_cnt;
    repeat (4) step();
    mem_ready = 1'b1;
    chk("bp_nopop", pop_cnt, p0);
    wait_hs(4, "bp_all");
    step();
    step();
    chk("bp_gap", hs_cyc[1] - hs_cyc[0], 6);
    chk("bp_addr1", 32'(hs_addr[1]), 32'h101);
    chk("bp_addr3", 32'(hs_addr[3]), 32'h103);
    chk("bp_ndone", done_cyc.size(), 1);

    // Restart while in REQ is ignored
    clear_logs();
    mem_ready = 1'b0;
    push(1);
    wait_req();
    start(18'h02000, 18'd8, 1'b0);
    mem_ready = 1'b1;
    wait_hs(1, "rs_wr");
    chk("rs_addr", 32'(hs_addr[0]), 32'h100);
    chk("rs_busy", 32'(dma_busy), 32'd1);
    capture_en = 1'b0;
    repeat (3) step();
    chk("rs_idle", 32'(dma_busy), 32'd0);
    chk("rs_wcnt", 32'(dma_wcnt), 32'd1);
    chk("rs_ndone", done_cyc.size(), 0);

    // Address wrap
    capture_en = 1'b1;
    clear_logs();
    push(4);
    start(18'h3FFFE, 18'd4, 1'b1);
    wait_hs(4, "wrap_all");
    repeat (2) step();
    chk("wrap_a0", 32'(hs_addr[0]), 32'h3FFFE);
    chk("wrap_a1", 32'(hs_addr[1]), 32'h3FFFF);
    chk("wrap_a2", 32'(hs_addr[2]), 32'h00000);
    chk("wrap_a3", 32'(hs_addr[3]), 32'h00001);
    chk("wrap_ndone", done_cyc.size(), 1);
    chk("wrap_busy", 32'(dma_busy), 32'd1);

    // Snapshot drain: capture_en drops with 3 words buffered
    clear_logs();
    push(3);
    capture_en = 1'b0;
    wait_hs(3, "drain_all");
    repeat (3) step();
    chk("drain_nwr", hs_addr.size(), 3);
    chk("drain_a2", 32'(hs_addr[2]), 32'h00000);
    chk("drain_ndone", done_cyc.size(), 0);
    chk("drain_idle", 32'(dma_busy), 32'd0);
    chk("drain_wcnt", 32'(dma_wcnt), 32'd3);

    // Zero-length start
    capture_en = 1'b1;
    clear_logs();
    start(18'h00055, 18'd0, 1'b1);
    repeat (3) step();
    chk("len0_ndone", done_cyc.size(), 1);
    chk("len0_at", done_cyc[0] - start_cyc, 1);
    chk("len0_noreq", req_cnt, 0);
    chk("len0_idle", 32'(dma_busy), 32'd0);

    // Async reset while a write is stalled
    clear_logs();
    mem_ready = 1'b0;
    push(1);
    start(18'h00100, 18'd4, 1'b1);
    wait_req();
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("arst");
    exp_q.delete();
    buf_q.delete();
    pop_seen = 1'b0;
    refresh();
    stall_prev = 1'b0;
    done_sched = 1'b0;
    start_zero = 1'b0;
    m_active = 1'b0;
    step();
    rst = 1'b0;
    mem_ready = 1'b1;
    step();
    clear_logs();
    push(4);
    start(18'h00100, 18'd4, 1'b1);
    repeat (10) step();
    chk_basic("again");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcmi_dma.md
# dcmi_dma

DMA write engine for the DCMI capture path. It sits downstream of the DCMI ping-pong buffer and the DCMI register file. It pops 32-bit captured words from the buffer and writes them to a word-addressed system SRAM port, starting at the programmed start address, for the programmed number of words. At the end of each block it pulses a done flag for the interrupt logic.

## Interface
Parameters:
- AW, 18, word-address and length width (matches dma_saddr/dma_len).

Ports:
- hclk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- capture_start  in  1  one-cycle pulse from the register file; arms a transfer.
- capture_en  in  1  capture enable level; cleared by hardware at snapshot frame end.
- dma_saddr  in  AW  start word address; sampled on accepted capture_start.
- dma_len  in  AW  block length in words; sampled on accepted capture_start.
- ppbuf_valid  in  1  buffer holds at least one word; ppbuf_rdata is valid.
- ppbuf_rdata  in  32  head word of the buffer.
- ppbuf_rd  out  1  pop strobe, combinational, one cycle per word.
- mem_req  out  1  write request to SRAM port.
- mem_addr  out  AW  write word address.
- mem_wdata  out  32  write data.
- mem_ready  in  1  SRAM accepts; a transfer occurs in any cycle where mem_req and mem_ready are both high.
- dma_busy  out  1  high in WAIT or REQ.
- dma_done  out  1  one-cycle pulse at block completion.
- dma_wcnt  out  AW  words written in the current block.

## Operation
- Internal registers: base (AW), len (AW), addr (AW), cnt (AW), wdata (32), state (IDLE/WAIT/REQ), done_r.
- IDLE:
  - On capture_start with dma_len != 0: base=addr=dma_saddr, len=dma_len, cnt=0, go to WAIT.
  - On capture_start with dma_len == 0: no transfer, dma_done pulses next cycle, stay in IDLE.
- WAIT:
  - If ppbuf_valid: ppbuf_rd=1 in this cycle, wdata<=ppbuf_rdata, go to REQ.
  - Else if capture_en==0: go to IDLE (abort or snapshot finished). Remaining buffered words are drained first, because ppbuf_valid is checked before capture_en.
- REQ:
  - mem_req=1, mem_addr=addr, mem_wdata=wdata, all held stable until mem_ready.
  - On handshake, if cnt+1 == len: done_r<=1, addr<=base, cnt<=0. Then go to WAIT if capture_en=1 (continuous, circular re-use of the same block); otherwise go to IDLE.
  - On handshake, otherwise: addr<=addr+1 (modulo 2^AW, so 3FFFF wraps to 0), cnt<=cnt+1, go to WAIT.
  - capture_en dropping in REQ never withdraws mem_req; the current write completes first.
- capture_start outside IDLE is ignored. Changes to dma_saddr/dma_len while busy have no effect until the next accepted start.
- ppbuf_rd is never asserted outside WAIT, and never when ppbuf_valid=0.
- dma_wcnt = cnt. dma_busy = (state != IDLE).

## Timing
- Reset (async, any state, including mid-request): state=IDLE. mem_req, ppbuf_rd, dma_busy, dma_done = 0. mem_addr, mem_wdata, dma_wcnt, base, len = 0. Any pending SRAM write is dropped.
- capture_start at cycle n → dma_busy=1 at n+1.
- ppbuf_valid seen in WAIT at cycle n → ppbuf_rd=1 at n, mem_req=1 at n+1.
- mem_ready at cycle m → mem_req=0 at m+1. The next pop is at m+1 at earliest.
- Peak throughput is one word per 2 cycles with zero wait states.
- dma_done is registered: it is high for exactly the one cycle after the final handshake.
- dma_len==0 start: dma_done high the cycle after capture_start.
- Reset during a dma_done cycle clears it immediately.

## Test plan
- Basic block: saddr=0x00100, len=4, capture_en=1, ppbuf_valid always, mem_ready always → writes to 0x100..0x103 on cycles 2,4,6,8 after start. dma_done one cycle after the 4th handshake. addr returns to 0x100 and the engine stays busy.
- Backpressure: mem_ready low for 5 cycles during the 2nd write → mem_req, mem_addr and mem_wdata stay constant and no extra ppbuf_rd; the write completes on the first ready.
- Wrap: saddr=0x3FFFE, len=4 → addresses 3FFFE, 3FFFF, 00000, 00001, then dma_done.
- Snapshot drain: capture_en falls while 3 words remain buffered → all 3 words are written, then IDLE with dma_busy=0 and no dma_done if len was not reached.
- len=0 and restart-while-busy: start with len=0 → dma_done pulse, no mem_req. A second capture_start during REQ → ignored; base and len unchanged.
- Async reset mid-REQ with mem_ready=0 → mem_req=0 immediately. All outputs at reset values. A new start afterwards behaves as in the basic-block case.
